// File: rtl/bt_host_port.sv
// Host endpoint for the Bluetooth UART peripheral: a TX FIFO feeds the peripheral's
// enable/busy handshake, and an RX FIFO collects bytes announced by its avail level.
module bt_host_port #(
  parameter int DEPTH_LOG2  = 4,
  parameter int ACK_TIMEOUT = 65535,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  tx_full,
  output logic [DEPTH_LOG2:0]   tx_count,
  output logic                  tx_err,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  rx_empty,
  output logic                  rx_overrun,
  input  logic                  err_clr,
  output logic [7:0]            bt_din,
  output logic                  bt_enable,
  input  logic                  bt_busy,
  input  logic                  bt_done,
  input  logic                  bt_avail,
  input  logic [7:0]            bt_dout
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TMAX  = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int TW    = $clog2(TMAX + 1);
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {T_IDLE, T_REQ, T_BUSY, T_GAP} tx_state_t;

  // Two-flop synchronisers for the link inputs, bit order {avail, done, busy}.
  logic [2:0] link_meta, link_sync;
  logic       avail_r;
  logic       busy_s, done_s, avail_s;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      link_meta <= '0;
      link_sync <= '0;
      avail_r   <= 1'b0;
    end else begin
      link_meta <= {bt_avail, bt_done, bt_busy};
      link_sync <= link_meta;
      avail_r   <= link_sync[2];
    end
  end

  assign busy_s  = link_sync[0];
  assign done_s  = link_sync[1];
  assign avail_s = link_sync[2];

  // done is synchronised for observability only; nothing sequences on it.
  logic unused_done;
  assign unused_done = done_s;

  // ---------------- RX path ----------------
  logic [7:0]            rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [DEPTH_LOG2:0]   rx_count;
  logic                  rx_capture, rx_pop, rx_push, rx_full, rx_drop;

  assign rx_full    = (rx_count == FULL_LEVEL);
  assign rx_empty   = (rx_count == '0);
  assign rx_capture = avail_s & ~avail_r;
  assign rx_pop     = rd_en & ~rx_empty;
  // A pop in the same cycle frees the slot, so a capture into a full FIFO still lands.
  assign rx_push    = rx_capture & (~rx_full | rx_pop);
  assign rx_drop    = rx_capture & rx_full & ~rx_pop;
  assign rd_data    = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];

  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= bt_dout;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      rx_count   <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
      if (rx_drop)      rx_overrun <= 1'b1;
      else if (err_clr) rx_overrun <= 1'b0;
    end
  end

  // ---------------- TX path ----------------
  logic [7:0]            tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr;
  logic                  tx_empty, tx_push, tx_pop, tx_timeout;
  tx_state_t             state_reg, state_next;
  logic [TW-1:0]         timer_reg, timer_next;

  assign tx_full  = (tx_count == FULL_LEVEL);
  assign tx_empty = (tx_count == '0);
  assign tx_push  = wr_en & (~tx_full | tx_pop);

  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= wr_data;
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    tx_pop     = 1'b0;
    tx_timeout = 1'b0;
    case (state_reg)
      T_IDLE: begin
        if (!tx_empty && !busy_s) begin
          tx_pop     = 1'b1;
          timer_next = '0;
          state_next = T_REQ;
        end
      end
      T_REQ: begin
        if (busy_s) begin
          state_next = T_BUSY;
        end else if (timer_reg == ACK_LAST) begin
          tx_timeout = 1'b1;
          timer_next = '0;
          state_next = T_GAP;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      T_BUSY: begin
        if (!busy_s) begin
          timer_next = '0;
          state_next = T_GAP;
        end
      end
      T_GAP: begin
        if (timer_reg == GAP_LAST) state_next = T_IDLE;
        else                       timer_next = timer_reg + 1'b1;
      end
      default: state_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_reg <= T_IDLE;
      timer_reg <= '0;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      tx_err    <= 1'b0;
      bt_din    <= 8'h00;
      bt_enable <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      // Enable is registered from the next state so it drops on the edge that leaves T_REQ.
      bt_enable <= (state_next == T_REQ);
      if (tx_pop) bt_din <= tx_mem[tx_rd_ptr];
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
      if (tx_timeout)   tx_err <= 1'b1;
      else if (err_clr) tx_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bt_host_port.sv
// Self-checking bench for bt_host_port: peripheral model, link monitor, queue-based RX model.
module tb_bt_host_port;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_full, tx_err, rx_empty, rx_overrun, bt_enable;
  logic [4:0] tx_count;
  logic [7:0] rd_data, bt_din;
  logic       bt_busy, bt_avail = 1'b0, bt_done = 1'b0;
  logic [7:0] bt_dout = 8'h00;
  logic       per_busy = 1'b0, force_busy = 1'b0;
  bit         per_auto = 1'b0;
  int         per_cnt = 0;

  int checks = 0;
  int errors = 0;

  assign bt_busy = per_busy | force_busy;

  bt_host_port #(.DEPTH_LOG2(4), .ACK_TIMEOUT(20), .GAP_CYCLES(4)) dut (
    .clk_in(clk_in), .reset(reset),
    .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full), .tx_count(tx_count), .tx_err(tx_err),
    .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty), .rx_overrun(rx_overrun),
    .err_clr(err_clr), .bt_din(bt_din), .bt_enable(bt_enable),
    .bt_busy(bt_busy), .bt_done(bt_done), .bt_avail(bt_avail), .bt_dout(bt_dout)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Peripheral: busy rises 2 cycles after enable is seen and is held for 100 cycles.
  always begin
    @(posedge clk_in); #1;
    if (!per_auto) begin
      per_busy = 1'b0;
      per_cnt  = 0;
    end else if (per_cnt == 0) begin
      if (bt_enable) per_cnt = 1;
    end else begin
      per_cnt++;
      if (per_cnt == 3) per_busy = 1'b1;
      if (per_cnt == 103) begin
        per_busy = 1'b0;
        per_cnt  = 0;
      end
    end
  end

  // Link monitor: bytes sent, enable lengths, busy->enable-fall latency, idle gap.
  logic [7:0] tx_seen [$];
  int         en_lens [$];
  logic       en_prev = 1'b0, busy_prev = 1'b0, din_changed = 1'b0, bl_active = 1'b0;
  logic [7:0] din_q = 8'h00;
  int         en_rises = 0, en_len = 0, bl = 0, max_bl = 0, min_gap = 1000, since_busy_fall = 1000;

  always @(negedge clk_in) begin
    if (bt_busy) since_busy_fall = 0;
    else if (since_busy_fall < 1000) since_busy_fall++;
    if (bl_active) begin
      bl++;
      if (!bt_enable) begin
        if (bl > max_bl) max_bl = bl;
        bl_active = 1'b0;
      end
    end
    if (bt_busy && !busy_prev) begin
      bl_active = bt_enable;
      bl = 0;
    end
    if (bt_enable && !en_prev) begin
      tx_seen.push_back(bt_din);
      en_rises++;
      en_len = 0;
      din_q = bt_din;
      if (since_busy_fall < min_gap) min_gap = since_busy_fall;
    end
    if (bt_enable) begin
      en_len++;
      if (bt_din !== din_q) din_changed = 1'b1;
    end else if (en_prev) begin
      en_lens.push_back(en_len);
    end
    en_prev   = bt_enable;
    busy_prev = bt_busy;
  end

  task automatic clr_mon();
    tx_seen.delete();
    en_lens.delete();
    en_rises = 0; max_bl = 0; min_gap = 1000; din_changed = 1'b0; bl_active = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // RX reference model: an ordered queue of stored bytes plus a sticky overrun flag.
  logic [7:0] rxq [$];
  bit         rx_ov_m = 1'b0;

  task automatic avail_pulse(input logic [7:0] d, input int hi, input int lo);
    bt_dout = d;
    bt_avail = 1'b1;
    repeat (hi) tick();
    bt_avail = 1'b0;
    repeat (lo) tick();
    if (rxq.size() < 16) rxq.push_back(d);
    else rx_ov_m = 1'b1;
  endtask

  task automatic rx_read();
    if (rxq.size() > 0) chk("rx head", 32'(rd_data), 32'(rxq[0]));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (rxq.size() > 0) void'(rxq.pop_front());
  endtask

  task automatic rx_state(input string name);
    chk({name, " empty"}, 32'(rx_empty), 32'(rxq.size() == 0));
    chk({name, " overrun"}, 32'(rx_overrun), 32'(rx_ov_m));
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic [4:0] exp_count;
    logic       exp_full;
  } tx_vec_t;
  tx_vec_t vec [18];

  logic [7:0] b;
  int         op;

  initial begin
    for (int i = 0; i < 17; i++) begin
      vec[i].wr        = 1'b1;
      vec[i].data      = 8'(8'h10 + i);
      vec[i].exp_count = (i < 16) ? 5'(i + 1) : 5'd16;
      vec[i].exp_full  = (i >= 15);
    end
    vec[17] = '{1'b0, 8'h00, 5'd16, 1'b1};

    // Reset values
    repeat (3) tick();
    chk("rst tx_full", 32'(tx_full), 0);
    chk("rst tx_count", 32'(tx_count), 0);
    chk("rst tx_err", 32'(tx_err), 0);
    chk("rst rx_empty", 32'(rx_empty), 1);
    chk("rst rx_overrun", 32'(rx_overrun), 0);
    chk("rst rd_data", 32'(rd_data), 0);
    chk("rst bt_din", 32'(bt_din), 0);
    chk("rst bt_enable", 32'(bt_enable), 0);
    reset = 1'b0;
    repeat (2) tick();

    // Single long avail pulse: one entry, 3-cycle latency
    bt_dout = 8'h5A;
    bt_avail = 1'b1;
    tick(); tick();
    chk("rx lat2 empty", 32'(rx_empty), 1);
    tick();
    chk("rx lat3 empty", 32'(rx_empty), 0);
    chk("rx lat3 data", 32'(rd_data), 32'h5A);
    repeat (37) tick();
    bt_avail = 1'b0;
    repeat (5) tick();
    chk("rx one entry", 32'(rx_empty), 0);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("rx popped empty", 32'(rx_empty), 1);

    // Randomized pulses / reads / clears against the queue model
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 5) avail_pulse(8'($urandom), int'($urandom_range(1, 10)), int'($urandom_range(4, 8)));
      else if (op <= 8) rx_read();
      else begin
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        rx_ov_m = 1'b0;
      end
      rx_state($sformatf("rand%0d", i));
    end
    while (rxq.size() > 0) rx_read();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    rx_ov_m = 1'b0;
    rx_state("drained");

    // 17 pulses with no reads: overrun only on the 17th
    for (int i = 0; i < 17; i++) begin
      avail_pulse(8'($urandom), 3, 4);
      if (i >= 15) rx_state($sformatf("fill%0d", i));
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    rx_ov_m = 1'b0;
    rx_state("after clr");

    // Capture into a full FIFO in the same cycle as a pop: accepted, no overrun
    bt_dout = 8'hE7;
    bt_avail = 1'b1;
    tick(); tick();
    chk("full pop head", 32'(rd_data), 32'(rxq[0]));
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    bt_avail = 1'b0;
    void'(rxq.pop_front());
    rxq.push_back(8'hE7);
    repeat (4) tick();
    rx_state("push+pop full");
    while (rxq.size() > 0) rx_read();
    rx_state("final drain");

    // TX: two bytes through the auto peripheral
    clr_mon();
    per_auto = 1'b1;
    wr_en = 1'b1; wr_data = 8'h41; tick();
    wr_data = 8'h42; tick();
    wr_en = 1'b0;
    for (int i = 0; i < 800 && !(tx_seen.size() >= 2 && !bt_busy && !bt_enable && tx_count == 0); i++) tick();
    repeat (10) tick();
    chk("tx2 enables", 32'(en_rises), 2);
    b = (tx_seen.size() > 0) ? tx_seen[0] : 8'hxx;
    chk("tx2 byte0", 32'(b), 32'h41);
    b = (tx_seen.size() > 1) ? tx_seen[1] : 8'hxx;
    chk("tx2 byte1", 32'(b), 32'h42);
    chk("tx2 count", 32'(tx_count), 0);
    chk("tx2 en fall<=3", 32'(max_bl <= 3 && max_bl > 0), 1);
    chk("tx2 gap>=4", 32'(min_gap >= 4 && min_gap < 1000), 1);
    chk("tx2 din held", 32'(din_changed), 0);
    chk("tx2 err", 32'(tx_err), 0);

    // TX fill with busy held: table of pushes
    per_auto = 1'b0;
    force_busy = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 18; i++) begin
      wr_en = vec[i].wr;
      wr_data = vec[i].data;
      tick();
      chk($sformatf("fill%0d count", i), 32'(tx_count), 32'(vec[i].exp_count));
      chk($sformatf("fill%0d full", i), 32'(tx_full), 32'(vec[i].exp_full));
    end
    wr_en = 1'b0;
    clr_mon();
    per_auto = 1'b1;
    force_busy = 1'b0;
    for (int i = 0; i < 3000 && !(tx_seen.size() >= 16 && tx_count == 0 && !bt_busy && !bt_enable); i++) tick();
    repeat (50) tick();
    chk("drain count", 32'(tx_seen.size()), 16);
    for (int i = 0; i < 16; i++) begin
      b = (i < tx_seen.size()) ? tx_seen[i] : 8'hxx;
      chk($sformatf("drain byte%0d", i), 32'(b), 32'(vec[i].data));
    end

    // Ack timeout: peripheral never answers
    per_auto = 1'b0;
    repeat (5) tick();
    clr_mon();
    wr_en = 1'b1; wr_data = 8'hC1; tick();
    wr_data = 8'hC2; tick();
    wr_en = 1'b0;
    for (int i = 0; i < 300 && en_lens.size() < 2; i++) tick();
    chk("to len0", 32'((en_lens.size() > 0) ? en_lens[0] : -1), 20);
    chk("to len1", 32'((en_lens.size() > 1) ? en_lens[1] : -1), 20);
    b = (tx_seen.size() > 1) ? tx_seen[1] : 8'hxx;
    chk("to next byte", 32'(b), 32'hC2);
    chk("to tx_err", 32'(tx_err), 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("to err_clr", 32'(tx_err), 0);

    // err_clr held across a timeout: the set wins
    repeat (10) tick();
    wr_en = 1'b1; wr_data = 8'hC3; tick();
    wr_en = 1'b0;
    for (int i = 0; i < 50 && !bt_enable; i++) tick();
    err_clr = 1'b1;
    repeat (19) tick();
    chk("clr holds err", 32'(tx_err), 0);
    tick();
    chk("set beats clr", 32'(tx_err), 1);
    err_clr = 1'b0;
    repeat (10) tick();

    // Reset while in T_BUSY with 3 bytes queued
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hD1 + i); tick();
    end
    wr_en = 1'b0;
    force_busy = 1'b1;
    for (int i = 0; i < 20 && bt_enable; i++) tick();
    repeat (2) tick();
    chk("busy queued", 32'(tx_count), 3);
    chk("busy err pre", 32'(tx_err), 1);
    reset = 1'b1; tick();
    chk("rst busy enable", 32'(bt_enable), 0);
    chk("rst busy count", 32'(tx_count), 0);
    chk("rst busy err", 32'(tx_err), 0);
    reset = 1'b0;
    force_busy = 1'b0;
    clr_mon();
    repeat (100) tick();
    chk("no enable after", 32'(en_rises), 0);

    // Reset while enable is high drops it on the next edge
    wr_en = 1'b1; wr_data = 8'hEE; tick();
    wr_en = 1'b0;
    for (int i = 0; i < 20 && !bt_enable; i++) tick();
    chk("req enable", 32'(bt_enable), 1);
    reset = 1'b1; tick();
    chk("rst req enable", 32'(bt_enable), 0);
    reset = 1'b0;
    clr_mon();
    repeat (50) tick();
    chk("req no enable", 32'(en_rises), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
